// File: rtl/run_ctrl_pkg.sv
// Shared types for the run-control / register-dump sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_OUT,
        ST_DONE
    } run_state_t;

    typedef enum logic [1:0] {
        HR_NONE    = 2'd0,
        HR_HALT    = 2'd1,
        HR_TIMEOUT = 2'd2
    } halt_reason_t;

endpackage

// File: rtl/run_ctrl_if.sv
// Register-dump stream: valid/ready handshake carrying register index and value.
interface run_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int IW = $clog2(NREGS);

    logic            valid;
    logic            ready;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] data;

    modport master (output valid, output idx, output data, input ready);
    modport slave  (input valid, input idx, input data, output ready);
endinterface

// File: rtl/run_ctrl_pc_stall_detector.sv
// Flags a halted CPU: PC unchanged for STALL_CYCLES consecutive enabled cycles.
module pc_stall_detector #(
    parameter int XLEN         = 32,
    parameter int STALL_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    output logic            stalled
);
    localparam int CW = $clog2(STALL_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STALL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TRIP = CW'(STALL_CYCLES - 2);

    logic [XLEN-1:0] prev_pc_q, prev_pc_d;
    logic            prev_vld_q, prev_vld_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            same;

    // Next-state for previous-PC and saturating repeat counter; stall decision.
    // The first enabled cycle after a clear has no previous PC and counts as a change.
    always_comb begin
        prev_pc_d  = prev_pc_q;
        prev_vld_d = prev_vld_q;
        cnt_d      = cnt_q;
        same       = prev_vld_q && (pc == prev_pc_q);
        if (clr) begin
            prev_vld_d = 1'b0;
            cnt_d      = '0;
        end else if (en) begin
            prev_pc_d  = pc;
            prev_vld_d = 1'b1;
            if (!same)
                cnt_d = '0;
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CW'(1);
        end
        stalled = en && !clr && same && (cnt_q == CNT_TRIP);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: hold CPU in reset, run it to halt or budget, then dump the register file.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 1000,
    parameter int STALL_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      cpu_rst,
    output logic                      cpu_en,
    input  logic [XLEN-1:0]           cpu_pc,
    output logic [$clog2(NREGS)-1:0]  rf_raddr,
    input  logic [XLEN-1:0]           rf_rdata,
    run_ctrl_if.master                dump,
    output logic [31:0]               cycle_count,
    output logic [1:0]                halt_reason,
    output logic                      done
);
    localparam int IW = $clog2(NREGS);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREGS - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [31:0]   MAX_CNT   = 32'(MAX_CYCLES);

    run_state_t      state_q, state_d;
    halt_reason_t    hr_q, hr_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     cyc_q, cyc_d, cyc_inc;
    logic            cpu_rst_q, cpu_rst_d;
    logic            cpu_en_q, cpu_en_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [IW-1:0]   didx_q, didx_d;
    logic [XLEN-1:0] ddata_q, ddata_d;
    logic            stall_clr, stall_en, stalled;

    pc_stall_detector #(
        .XLEN        (XLEN),
        .STALL_CYCLES(STALL_CYCLES)
    ) u_stall (
        .clk    (clk),
        .rst    (rst),
        .clr    (stall_clr),
        .en     (stall_en),
        .pc     (cpu_pc),
        .stalled(stalled)
    );

    assign stall_en = (state_q == ST_RUN);

    // Next-state, counters and dump capture; registered outputs derive from the next state
    // so they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        hr_d      = hr_q;
        rcnt_d    = rcnt_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        didx_d    = didx_q;
        ddata_d   = ddata_q;
        stall_clr = 1'b0;
        cyc_inc   = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RESET;
                    cyc_d     = '0;
                    hr_d      = HR_NONE;
                    rcnt_d    = '0;
                    stall_clr = 1'b1;
                end
            end
            ST_RESET: begin
                if (rcnt_q == RCNT_LAST)
                    state_d = ST_RUN;
                else
                    rcnt_d = rcnt_q + RW'(1);
            end
            ST_RUN: begin
                cyc_d = cyc_inc;
                if (stalled) begin
                    hr_d    = HR_HALT;
                    idx_d   = '0;
                    state_d = ST_DUMP_RD;
                end else if (cyc_inc == MAX_CNT) begin
                    hr_d    = HR_TIMEOUT;
                    idx_d   = '0;
                    state_d = ST_DUMP_RD;
                end
            end
            ST_DUMP_RD: begin
                ddata_d = rf_rdata;
                didx_d  = idx_q;
                state_d = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (dump.ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_DUMP_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cpu_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
        cpu_en_d  = (state_d == ST_RUN);
        valid_d   = (state_d == ST_DUMP_OUT);
        done_d    = (state_d == ST_DONE);
    end

    // Read address is decoded from the current state so read data is valid in DUMP_RD.
    always_comb begin
        rf_raddr = (state_q == ST_DUMP_RD) ? idx_q : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hr_q      <= HR_NONE;
            rcnt_q    <= '0;
            idx_q     <= '0;
            cyc_q     <= '0;
            cpu_rst_q <= 1'b1;
            cpu_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            didx_q    <= '0;
            ddata_q   <= '0;
        end else begin
            state_q   <= state_d;
            hr_q      <= hr_d;
            rcnt_q    <= rcnt_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_en_q  <= cpu_en_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            didx_q    <= didx_d;
            ddata_q   <= ddata_d;
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign cpu_en      = cpu_en_q;
    assign cycle_count = cyc_q;
    assign halt_reason = hr_q;
    assign done        = done_q;
    assign dump.valid  = valid_q;
    assign dump.idx    = didx_q;
    assign dump.data   = ddata_q;
endmodule
